switch_filter: RTL

SWITCH_FILTER -- requirements
Module: switch_filter

---
 rtl/switch_filter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/switch_filter.sv
`default_nettype none
// ============================================================================
// Module   : switch_filter
// Purpose  : Multi-channel switch debouncer. Each channel is synchronised,
//            filtered by a per-channel stability counter clocked by a shared
//            prescaler tick, and reports rise / fall / long-press pulses.
// Revision : 1.0 - initial release
// ============================================================================
module switch_filter #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_WIDTH   = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               PRESCALE    = 1,
  parameter int               HOLD_WIDTH  = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] iv_input,
  output logic [WIDTH-1:0] ov_output,
  output logic [WIDTH-1:0] ov_rise,
  output logic [WIDTH-1:0] ov_fall,
  output logic [WIDTH-1:0] ov_hold,
  output logic             o_tick
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     w_s;
  logic [PS_W-1:0]      ps_q;
  logic                 tick_q;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     rise_q, rise_d;
  logic [WIDTH-1:0]     fall_q, fall_d;
  logic [WIDTH-1:0]     w_edge;

  assign w_s = sync_q[SYNC_STAGES-1];

  // Metastability chain on the raw switch levels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT_VALUE;
    end else begin
      sync_q[0] <= iv_input;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Free-running prescaler; the tick is registered so it is 1 on every cycle when PRESCALE=1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
      tick_q <= (ps_q == PS_LAST);
    end
  end

  // Stability filter: any match clears the count; a full run of mismatching ticks commits the new level.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_s[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == '1) begin
          cnt_d[i]  = '0;
          out_d[i]  = w_s[i];
          rise_d[i] = w_s[i];
          fall_d[i] = ~w_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign w_edge = rise_d | fall_d;

  // Filter state and edge pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      out_q  <= INIT_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  generate
    if (HOLD_WIDTH > 0) begin : g_hold
      logic [HOLD_WIDTH-1:0] hcnt_q [WIDTH];
      logic [HOLD_WIDTH-1:0] hcnt_d [WIDTH];
      logic [WIDTH-1:0]      hdone_q, hdone_d;
      logic [WIDTH-1:0]      hold_q, hold_d;

      // Long-press detect: the pulse fires on the first tick seen with the counter already
      // saturated, i.e. after 2^HOLD_WIDTH ticks at 1; a coincident fall wins over the hold.
      always_comb begin
        hcnt_d  = hcnt_q;
        hdone_d = hdone_q;
        hold_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (!out_q[i]) begin
            hcnt_d[i]  = '0;
            hdone_d[i] = 1'b0;
          end else if (tick_q) begin
            if (hcnt_q[i] != '1) begin
              hcnt_d[i] = hcnt_q[i] + HOLD_WIDTH'(1);
            end else if (!hdone_q[i] && !w_edge[i]) begin
              hold_d[i]  = 1'b1;
              hdone_d[i] = 1'b1;
            end
          end
        end
      end

      // Hold counter, one-shot flag and pulse registers.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < WIDTH; i++) hcnt_q[i] <= '0;
          hdone_q <= '0;
          hold_q  <= '0;
        end else begin
          hcnt_q  <= hcnt_d;
          hdone_q <= hdone_d;
          hold_q  <= hold_d;
        end
      end

      assign ov_hold = hold_q;
    end else begin : g_no_hold
      assign ov_hold = '0;
    end
  endgenerate

  assign ov_output = out_q;
  assign ov_rise   = rise_q;
  assign ov_fall   = fall_q;
  assign o_tick    = tick_q;

endmodule
`default_nettype wire
